// File: rtl/adder_pipe_flow.sv
// adder_pipe_flow: valid/ready shell in front of the pipelined adder (adder_pipe).
// Operands are issued into the adder (which cannot stall), a valid delay line
// matched to the adder latency marks returning results, and results land in a
// small FIFO. A credit counter limits issue so a result never meets a full FIFO.
//
// Optional build macro: ADDER_PIPE_FLOW_TAG_EN adds in_tag/out_tag. The tag
// rides its own delay line beside the valid bit and is stored with the result.

module adder_pipe_flow #(
    parameter int WIDTH      = 16,
    parameter int NUM_ADDERS = 4,
    parameter int DEPTH      = 5,
    parameter int TAG_W      = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,

    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_a,
    input  logic [WIDTH-1:0]           in_b,
    input  logic                       in_cin,
`ifdef ADDER_PIPE_FLOW_TAG_EN
    input  logic [TAG_W-1:0]           in_tag,
    output logic [TAG_W-1:0]           out_tag,
`endif

    output logic [WIDTH-1:0]           add_in0,
    output logic [WIDTH-1:0]           add_in1,
    output logic                       add_cin,
    input  logic [WIDTH-1:0]           add_sum,
    input  logic                       add_cout,

    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_sum,
    output logic                       out_cout,
    output logic [$clog2(DEPTH+1)-1:0] inflight
);

    // Adder latency; the delay line keeps at least one stage so the vectors
    // stay legal when the adder is purely combinational (L = 0).
    localparam int L     = NUM_ADDERS - 1;
    localparam int VL    = (L > 0) ? L : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef ADDER_PIPE_FLOW_TAG_EN
    localparam int EW    = WIDTH + 1 + TAG_W;
`else
    localparam int EW    = WIDTH + 1;
`endif

    if (NUM_ADDERS < 1 || DEPTH < 1 || WIDTH < 1 || TAG_W < 1) begin : g_bad_param
        $error("adder_pipe_flow: illegal parameter value");
    end

    logic             fire_in;
    logic             fire_out;
    logic             strobe;

    logic [CNT_W-1:0] credits_q, credits_d;
    logic [CNT_W-1:0] inflight_q, inflight_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [VL-1:0]    vld_q, vld_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [EW-1:0]    mem_q [DEPTH];
    logic [EW-1:0]    mem_d [DEPTH];
    logic [EW-1:0]    wr_data;
    logic [EW-1:0]    head;

`ifdef ADDER_PIPE_FLOW_TAG_EN
    logic [TAG_W-1:0] tag_q [VL];
    logic [TAG_W-1:0] tag_d [VL];
    logic [TAG_W-1:0] strobe_tag;
`endif

    // Pointer advance with wrap at DEPTH, which need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    // Issue handshake; in_ready depends only on the credit register.
    always_comb begin
        in_ready  = (credits_q != '0);
        fire_in   = in_valid & in_ready;
        out_valid = (count_q != '0);
        fire_out  = out_valid & out_ready;
        add_in0   = fire_in ? in_a   : '0;
        add_in1   = fire_in ? in_b   : '0;
        add_cin   = fire_in ? in_cin : 1'b0;
    end

    // Valid delay line matched to the adder latency; its last stage is the arrival strobe.
    always_comb begin
        vld_d    = '0;
        vld_d[0] = fire_in;
        for (int i = 1; i < VL; i++) begin
            vld_d[i] = vld_q[i-1];
        end
        strobe = (L == 0) ? fire_in : vld_q[VL-1];
    end

`ifdef ADDER_PIPE_FLOW_TAG_EN
    // Tag delay line travelling alongside the valid bit.
    always_comb begin
        for (int i = 0; i < VL; i++) begin
            tag_d[i] = tag_q[i];
        end
        tag_d[0] = in_tag;
        for (int i = 1; i < VL; i++) begin
            tag_d[i] = tag_q[i-1];
        end
        strobe_tag = (L == 0) ? in_tag : tag_q[VL-1];
    end
`endif

    // Result FIFO: write the adder output on the strobe, advance the head on pop.
    always_comb begin
`ifdef ADDER_PIPE_FLOW_TAG_EN
        wr_data = {add_sum, add_cout, strobe_tag};
`else
        wr_data = {add_sum, add_cout};
`endif
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (strobe) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (fire_out) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({strobe, fire_out})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO head fields.
    always_comb begin
        head     = mem_q[rd_ptr_q];
        out_sum  = head[EW-1 -: WIDTH];
        out_cout = head[EW-1-WIDTH];
`ifdef ADDER_PIPE_FLOW_TAG_EN
        out_tag  = head[TAG_W-1:0];
`endif
    end

    // Credits: one taken per issue, one returned per pop; inflight mirrors DEPTH - credits.
    always_comb begin
        credits_d = credits_q;
        case ({fire_in, fire_out})
            2'b10:   credits_d = credits_q - CNT_W'(1);
            2'b01:   credits_d = credits_q + CNT_W'(1);
            default: credits_d = credits_q;
        endcase
        inflight_d = CNT_W'(DEPTH) - credits_d;
        inflight   = inflight_q;
    end

    // Control state with synchronous reset; reset also drops results still in the adder.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            credits_q  <= CNT_W'(DEPTH);
            inflight_q <= '0;
            count_q    <= '0;
            vld_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            credits_q  <= credits_d;
            inflight_q <= inflight_d;
            count_q    <= count_d;
            vld_q      <= vld_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    // Data storage needs no reset; contents are only read behind out_valid.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
        end
    end

`ifdef ADDER_PIPE_FLOW_TAG_EN
    // Tag pipeline registers; meaningful only where the valid line is set.
    always_ff @(posedge clk) begin
        for (int i = 0; i < VL; i++) begin
            tag_q[i] <= tag_d[i];
        end
    end
`endif

`ifndef SYNTHESIS
    // A result arriving at a full FIFO means the credit accounting is broken.
    always @(posedge clk) begin
        if (rst_n) begin
            assert (!(strobe && (count_q == CNT_W'(DEPTH))))
            else $error("adder_pipe_flow: result arrived while FIFO full");
        end
    end
`endif

endmodule

// File: tb/tb_adder_pipe_flow.sv
// Bench for adder_pipe_flow: models adder_pipe as a latency-L register pipe,
// drives directed and random traffic, and checks against a queue-based model.

module tb_adder_pipe_flow;

    localparam int WIDTH      = 16;
    localparam int NUM_ADDERS = 4;
    localparam int DEPTH      = 5;
    localparam int TAG_W      = 4;
    localparam int L          = NUM_ADDERS - 1;
    localparam int CNT_W      = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a, in_b;
    logic             in_cin;
    logic [TAG_W-1:0] in_tag;
    logic [TAG_W-1:0] out_tag;
    logic [WIDTH-1:0] add_in0, add_in1, add_sum;
    logic             add_cin, add_cout;
    logic             out_valid, out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic [CNT_W-1:0] inflight;

    adder_pipe_flow #(
        .WIDTH(WIDTH), .NUM_ADDERS(NUM_ADDERS), .DEPTH(DEPTH), .TAG_W(TAG_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
`ifdef ADDER_PIPE_FLOW_TAG_EN
        .in_tag(in_tag), .out_tag(out_tag),
`endif
        .add_in0(add_in0), .add_in1(add_in1), .add_cin(add_cin),
        .add_sum(add_sum), .add_cout(add_cout),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_cout(out_cout),
        .inflight(inflight)
    );

`ifndef ADDER_PIPE_FLOW_TAG_EN
    assign out_tag = '0;
`endif

    always #5 clk = ~clk;

    // Stand-in for adder_pipe: inputs of cycle t appear on add_sum/add_cout in cycle t+L.
    logic [WIDTH:0] apipe [L];
    initial for (int i = 0; i < L; i++) apipe[i] = '0;
    always @(posedge clk) begin
        for (int i = L - 1; i > 0; i--) apipe[i] <= apipe[i-1];
        apipe[0] <= {1'b0, add_in0} + {1'b0, add_in1} + {{WIDTH{1'b0}}, add_cin};
    end
    assign {add_cout, add_sum} = apipe[L-1];

    int n_cmp = 0;
    int n_mis = 0;
    int cyc   = 0;
    bit chk_en = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference model: every accepted op waits in this queue until popped.
    typedef struct {
        logic [WIDTH:0]   res;
        logic [TAG_W-1:0] tag;
        int               cyc;
    } exp_t;
    exp_t eq[$];

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (chk_en) begin
            logic        fin;
            logic        exp_ov;
            exp_t        e;
            exp_ov = (eq.size() > 0) && (eq[0].cyc + L + 1 <= cyc);
            check_eq("in_ready", in_ready, eq.size() < DEPTH);
            check_eq("inflight", inflight, eq.size());
            check_eq("out_valid", out_valid, exp_ov);
            fin = in_valid & in_ready;
            check_eq("adder_drive", {add_in0, add_in1, add_cin},
                     fin ? {in_a, in_b, in_cin} : {(2*WIDTH+1){1'b0}});
            if (!rst_n) begin
                eq.delete();
            end else begin
                if (out_valid && out_ready) begin
                    if (eq.size() == 0) begin
                        check_eq("pop_when_empty", out_valid, 1'b0);
                    end else begin
                        e = eq.pop_front();
                        check_eq("result", {out_cout, out_sum}, e.res);
`ifdef ADDER_PIPE_FLOW_TAG_EN
                        check_eq("tag", out_tag, e.tag);
`endif
                    end
                end
                if (fin) begin
                    e.res = {1'b0, in_a} + {1'b0, in_b} + {{WIDTH{1'b0}}, in_cin};
                    e.tag = in_tag;
                    e.cyc = cyc;
                    eq.push_back(e);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic single_op(input string name, input logic [WIDTH-1:0] a,
                             input logic [WIDTH-1:0] b, input logic c,
                             input logic [WIDTH-1:0] exp_sum, input logic exp_cout);
        in_valid = 1'b1; in_a = a; in_b = b; in_cin = c; out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        step();
        step();
        @(negedge clk);
        check_eq({name, "_early"}, out_valid, 1'b0);
        step();
        out_ready = 1'b1;
        @(negedge clk);
        check_eq({name, "_valid"}, out_valid, 1'b1);
        check_eq({name, "_sum"}, out_sum, exp_sum);
        check_eq({name, "_cout"}, out_cout, exp_cout);
        step();
        out_ready = 1'b0;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (eq.size() == 0) break;
            step();
        end
        check_eq("drain_empty", eq.size(), 0);
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        int acc;
        bit ok;
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        bit ok;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_a = '0; in_b = '0; in_cin = 1'b0; in_tag = '0;
        step();
        step();
        chk_en = 1'b1;
        @(negedge clk);
        check_eq("rst_in_ready", in_ready, 1'b1);
        check_eq("rst_out_valid", out_valid, 1'b0);
        check_eq("rst_inflight", inflight, 0);
        step();
        rst_n = 1'b1;
        step();

        single_op("single", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0);
        single_op("carry",  16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1);

        // Back-to-back streaming at full rate.
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1; in_a = WIDTH'($urandom); in_b = WIDTH'($urandom);
            in_cin = 1'($urandom); in_tag = TAG_W'($urandom);
            @(negedge clk);
            check_eq("b2b_ready", in_ready, 1'b1);
            step();
        end
        drain();

        // Backpressure: consumer stalled, exactly DEPTH ops accepted.
        acc = 0;
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_a = WIDTH'($urandom); in_b = WIDTH'($urandom);
            in_cin = 1'($urandom); in_tag = TAG_W'($urandom);
            @(negedge clk);
            if (in_ready) acc++;
            step();
        end
        in_valid = 1'b0;
        check_eq("bp_accepted", acc, DEPTH);
        @(negedge clk);
        check_eq("bp_ready_low", in_ready, 1'b0);
        check_eq("bp_inflight", inflight, DEPTH);
        step();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        @(negedge clk);
        check_eq("bp_credit_back", in_ready, 1'b1);
        check_eq("bp_inflight_dec", inflight, DEPTH - 1);
        step();
        drain();

        // Reset with three ops in flight.
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_a = WIDTH'($urandom); in_b = WIDTH'($urandom);
            in_cin = 1'($urandom);
            if (i == 2) rst_n = 1'b0;
            step();
        end
        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check_eq("rstmid_out_valid", out_valid, 1'b0);
            check_eq("rstmid_inflight", inflight, 0);
            step();
        end
        out_ready = 1'b0;

`ifdef ADDER_PIPE_FLOW_TAG_EN
        in_valid = 1'b1; in_a = 16'h0010; in_b = 16'h0020; in_cin = 1'b0; in_tag = 4'h3;
        step();
        in_a = 16'h1000; in_b = 16'h0002; in_cin = 1'b1; in_tag = 4'hA;
        step();
        in_valid = 1'b0;
        ok = 1'b0;
        for (int k = 0; k < 10 && !ok; k++) begin
            @(negedge clk);
            if (out_valid) ok = 1'b1;
            else step();
        end
        check_eq("tag_wait", ok, 1'b1);
        check_eq("tag_first", out_tag, 4'h3);
        check_eq("tag_first_sum", out_sum, 16'h0030);
        step();
        out_ready = 1'b1;
        step();
        @(negedge clk);
        check_eq("tag_second", out_tag, 4'hA);
        check_eq("tag_second_sum", out_sum, 16'h1003);
        step();
        drain();
`endif

        // Random traffic with random backpressure.
        for (int i = 0; i < 300; i++) begin
            in_valid  = ($urandom_range(3) != 0);
            out_ready = ($urandom_range(2) != 0);
            in_a   = ($urandom_range(7) == 0) ? {WIDTH{1'b1}} : WIDTH'($urandom);
            in_b   = WIDTH'($urandom);
            in_cin = 1'($urandom);
            in_tag = TAG_W'($urandom);
            step();
        end
        drain();

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
